// File: rtl/scv_bus_waitgen.sv
// scv_bus_waitgen
//   Address decoder and programmable wait-state generator for the uPD7800
//   external bus. Decodes the CPU address into NREG chip-select regions,
//   muxes the selected region's read data onto db_i, and holds waitb low
//   for a per-region number of CP1 periods at the start of each access.
//
// Ports
//   clk          system clock
//   res          asynchronous reset, active-high
//   cp1_posedge  CP1 rising-edge enable; the FSM only advances when set
//   a            CPU address
//   rdb, wrb     CPU read / write strobes, active-low
//   region_base  region n base address in [n*AW +: AW]
//   region_mask  region n compare mask (1 = bit is compared)
//   region_wait  region n wait count in [n*WCW +: WCW]
//   rdata        region n read data in [n*DW +: DW]
//   ncs          active-low chip selects (one-hot-low or all ones)
//   db_i         read data to the CPU (all ones when not driven by a region)
//   waitb        active-low wait to the CPU
//   bus_err      one-clk pulse when an access hits no region
//   busy         high while the FSM is inserting wait states
module scv_bus_waitgen #(
  parameter int NREG = 4,
  parameter int AW   = 16,
  parameter int DW   = 8,
  parameter int WCW  = 3
) (
  input  logic                clk,
  input  logic                res,
  input  logic                cp1_posedge,
  input  logic [AW-1:0]       a,
  input  logic                rdb,
  input  logic                wrb,
  input  logic [NREG*AW-1:0]  region_base,
  input  logic [NREG*AW-1:0]  region_mask,
  input  logic [NREG*WCW-1:0] region_wait,
  input  logic [NREG*DW-1:0]  rdata,
  output logic [NREG-1:0]     ncs,
  output logic [DW-1:0]       db_i,
  output logic                waitb,
  output logic                bus_err,
  output logic                busy
);

  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  logic [NREG-1:0] hit;
  logic [NREG-1:0] sel_oh;
  logic [IW-1:0]   sel_idx;
  logic            any_hit;
  logic [WCW-1:0]  sel_wait;
  logic [DW-1:0]   sel_data;
  logic            active;

  state_t          state_reg;
  logic [WCW-1:0]  cnt_reg;
  logic            waitb_reg;
  logic            busy_reg;
  logic            bus_err_reg;

  // Per-region address compare.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_hit
      assign hit[gi] = ((a & region_mask[gi*AW +: AW]) ==
                        (region_base[gi*AW +: AW] & region_mask[gi*AW +: AW]));
    end
  endgenerate

  // Priority encode: scanning from the top down lets the lowest hitting
  // index overwrite any higher one.
  always_comb begin
    sel_idx = '0;
    any_hit = 1'b0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel_idx = IW'(i);
        any_hit = 1'b1;
      end
    end
  end

  generate
    for (gi = 0; gi < NREG; gi++) begin : g_sel
      assign sel_oh[gi] = any_hit && (sel_idx == IW'(gi));
    end
  endgenerate

  assign sel_wait = region_wait[sel_idx*WCW +: WCW];
  assign sel_data = rdata[sel_idx*DW +: DW];
  assign active   = ~rdb | ~wrb;

  assign ncs  = ~sel_oh;
  // Data only passes once the wait phase is over; otherwise float high.
  assign db_i = (waitb_reg && any_hit) ? sel_data : {DW{1'b1}};

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      waitb_reg   <= 1'b1;
      busy_reg    <= 1'b0;
      bus_err_reg <= 1'b0;
    end else begin
      // bus_err lasts exactly one clk, independent of the CP1 enable.
      bus_err_reg <= 1'b0;
      if (cp1_posedge) begin
        case (state_reg)
          ST_IDLE: begin
            if (active) begin
              if (!any_hit) begin
                bus_err_reg <= 1'b1;
                state_reg   <= ST_READY;
              end else if (sel_wait == '0) begin
                state_reg   <= ST_READY;
              end else begin
                // Wait count is captured here; later config changes are ignored.
                cnt_reg     <= sel_wait;
                waitb_reg   <= 1'b0;
                busy_reg    <= 1'b1;
                state_reg   <= ST_WAIT;
              end
            end
          end
          ST_WAIT: begin
            if (!active) begin
              // Strobe dropped mid-wait: abort straight back to idle.
              waitb_reg <= 1'b1;
              busy_reg  <= 1'b0;
              state_reg <= ST_IDLE;
            end else begin
              cnt_reg <= cnt_reg - WCW'(1);
              if (cnt_reg == WCW'(1)) begin
                waitb_reg <= 1'b1;
                busy_reg  <= 1'b0;
                state_reg <= ST_READY;
              end
            end
          end
          ST_READY: begin
            // A strobe held low keeps us here, so no second wait is inserted.
            if (!active) begin
              state_reg <= ST_IDLE;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign waitb   = waitb_reg;
  assign busy    = busy_reg;
  assign bus_err = bus_err_reg;

endmodule

// File: tb/tb_scv_bus_waitgen.sv
module tb_scv_bus_waitgen;

  localparam int NREG = 4;
  localparam int AW   = 16;
  localparam int DW   = 8;
  localparam int WCW  = 3;

  logic                clk = 1'b0;
  logic                res;
  logic                cp1_posedge;
  logic [AW-1:0]       a;
  logic                rdb;
  logic                wrb;
  logic [NREG*AW-1:0]  region_base;
  logic [NREG*AW-1:0]  region_mask;
  logic [NREG*WCW-1:0] region_wait;
  logic [NREG*DW-1:0]  rdata;
  logic [NREG-1:0]     ncs;
  logic [DW-1:0]       db_i;
  logic                waitb;
  logic                bus_err;
  logic                busy;

  int n_cmp = 0;
  int n_err = 0;

  scv_bus_waitgen #(.NREG(NREG), .AW(AW), .DW(DW), .WCW(WCW)) dut (
    .clk         (clk),
    .res         (res),
    .cp1_posedge (cp1_posedge),
    .a           (a),
    .rdb         (rdb),
    .wrb         (wrb),
    .region_base (region_base),
    .region_mask (region_mask),
    .region_wait (region_wait),
    .rdata       (rdata),
    .ncs         (ncs),
    .db_i        (db_i),
    .waitb       (waitb),
    .bus_err     (bus_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdb;
    logic        wrb;
    logic [15:0] a;
    logic        cp1;
    logic [3:0]  ncs;
    logic        waitb;
    logic        busy;
    logic        bus_err;
    logic [7:0]  db;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic add(input logic r, input logic w, input logic [15:0] ad, input logic c,
                     input logic [3:0] n, input logic wb, input logic bz, input logic be,
                     input logic [7:0] d);
    vec_t v;
    v.rdb = r; v.wrb = w; v.a = ad; v.cp1 = c;
    v.ncs = n; v.waitb = wb; v.busy = bz; v.bus_err = be; v.db = d;
    vecs.push_back(v);
  endtask

  // One dead clk, then one clk with the CP1 enable; returns at the
  // falling edge right after the enabled rising edge.
  task automatic tick();
    @(negedge clk);
    cp1_posedge = 1'b1;
    @(negedge clk);
    cp1_posedge = 1'b0;
  endtask

  // Counts further CP1 samples during which waitb stays low (bounded).
  task automatic count_rest(output int n);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (waitb !== 1'b0) break;
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    res         = 1'b1;
    cp1_posedge = 1'b0;
    a           = 16'h3123;
    rdb         = 1'b0;
    wrb         = 1'b0;
    rdata       = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    region_base = {16'h0000, 16'h4000, 16'h3000, 16'h0000};
    region_mask = {16'h0000, 16'hF000, 16'hFC00, 16'hF000};
    region_wait = {3'd7, 3'd2, 3'd3, 3'd0};

    // Reset held with both strobes low: nothing may start.
    tick(); tick();
    chk("reset waitb", 32'(waitb), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset bus_err", 32'(bus_err), 32'd0);

    // First CP1 sample after reset release starts a fresh wait.
    res = 1'b0; wrb = 1'b1;
    tick();
    chk("post-reset waitb", 32'(waitb), 32'd0);
    chk("post-reset busy", 32'(busy), 32'd1);
    rdb = 1'b1;
    tick();
    chk("post-reset abort waitb", 32'(waitb), 32'd1);
    chk("post-reset abort busy", 32'(busy), 32'd0);

    // rdb wrb a cp1 | ncs waitb busy bus_err db
    // Region 1, 3 waits.
    add(1, 1, 16'h3123, 1, 4'b1101, 1, 0, 0, 8'hB1);
    add(0, 1, 16'h3123, 0, 4'b1101, 1, 0, 0, 8'hB1);
    add(0, 1, 16'h3123, 1, 4'b1101, 0, 1, 0, 8'hFF);
    add(0, 1, 16'h3123, 1, 4'b1101, 0, 1, 0, 8'hFF);
    add(0, 1, 16'h3123, 0, 4'b1101, 0, 1, 0, 8'hFF);
    add(0, 1, 16'h3123, 1, 4'b1101, 0, 1, 0, 8'hFF);
    add(0, 1, 16'h3123, 1, 4'b1101, 1, 0, 0, 8'hB1);
    add(0, 1, 16'h3123, 1, 4'b1101, 1, 0, 0, 8'hB1);
    add(1, 1, 16'h3123, 1, 4'b1101, 1, 0, 0, 8'hB1);
    // Region 0 wins, zero wait.
    add(0, 1, 16'h0ABC, 1, 4'b1110, 1, 0, 0, 8'hA0);
    add(0, 1, 16'h0ABC, 1, 4'b1110, 1, 0, 0, 8'hA0);
    add(1, 1, 16'h0ABC, 1, 4'b1110, 1, 0, 0, 8'hA0);
    // Catch-all region 3, 7 waits; address moves mid-wait.
    add(0, 1, 16'h8000, 1, 4'b0111, 0, 1, 0, 8'hFF);
    add(0, 1, 16'h8000, 1, 4'b0111, 0, 1, 0, 8'hFF);
    add(0, 1, 16'h0ABC, 1, 4'b1110, 0, 1, 0, 8'hFF);
    add(0, 1, 16'h8000, 1, 4'b0111, 0, 1, 0, 8'hFF);
    add(0, 1, 16'h8000, 1, 4'b0111, 0, 1, 0, 8'hFF);
    add(0, 1, 16'h8000, 1, 4'b0111, 0, 1, 0, 8'hFF);
    add(0, 1, 16'h8000, 1, 4'b0111, 0, 1, 0, 8'hFF);
    add(0, 1, 16'h8000, 1, 4'b0111, 1, 0, 0, 8'hD3);
    add(1, 1, 16'h8000, 1, 4'b0111, 1, 0, 0, 8'hD3);
    // Write to region 2, 2 waits.
    add(1, 0, 16'h4ABC, 1, 4'b1011, 0, 1, 0, 8'hFF);
    add(1, 0, 16'h4ABC, 1, 4'b1011, 0, 1, 0, 8'hFF);
    add(1, 0, 16'h4ABC, 1, 4'b1011, 1, 0, 0, 8'hC2);
    add(1, 1, 16'h4ABC, 1, 4'b1011, 1, 0, 0, 8'hC2);

    foreach (vecs[i]) begin
      rdb = vecs[i].rdb; wrb = vecs[i].wrb; a = vecs[i].a;
      cp1_posedge = vecs[i].cp1;
      @(negedge clk);
      cp1_posedge = 1'b0;
      chk($sformatf("vec%0d ncs", i), 32'(ncs), 32'(vecs[i].ncs));
      chk($sformatf("vec%0d waitb", i), 32'(waitb), 32'(vecs[i].waitb));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d bus_err", i), 32'(bus_err), 32'(vecs[i].bus_err));
      chk($sformatf("vec%0d db_i", i), 32'(db_i), 32'(vecs[i].db));
    end

    // Abort: region 2 set to 5 waits, strobe released after 2 wait samples.
    region_wait[2*WCW +: WCW] = 3'd5;
    a = 16'h4000; rdb = 1'b0;
    tick(); tick(); tick();
    chk("abort pre waitb", 32'(waitb), 32'd0);
    rdb = 1'b1;
    tick();
    chk("abort waitb", 32'(waitb), 32'd1);
    chk("abort busy", 32'(busy), 32'd0);
    tick();
    rdb = 1'b0;
    tick();
    chk("abort restart waitb", 32'(waitb), 32'd0);
    count_rest(n);
    chk("abort restart low periods", 32'(n + 1), 32'd5);
    rdb = 1'b1;
    tick();

    // Wait count is locked in at the start of the access.
    rdb = 1'b0;
    tick();
    region_wait[2*WCW +: WCW] = 3'd1;
    count_rest(n);
    chk("config-change low periods", 32'(n + 1), 32'd5);
    rdb = 1'b1;
    tick();

    // Asynchronous reset mid-wait with counter at 4.
    a = 16'h8000; rdb = 1'b0;
    tick(); tick(); tick(); tick();
    chk("midwait waitb", 32'(waitb), 32'd0);
    #2 res = 1'b1;
    #1;
    chk("async reset waitb", 32'(waitb), 32'd1);
    chk("async reset busy", 32'(busy), 32'd0);
    @(negedge clk);
    res = 1'b0;
    tick();
    count_rest(n);
    chk("after reset low periods", 32'(n + 1), 32'd7);
    rdb = 1'b1;
    tick();

    // Unmapped write.
    region_mask = {4{16'hFFFF}};
    region_base = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    a = 16'h5555; wrb = 1'b0;
    #1;
    chk("unmapped ncs", 32'(ncs), 32'hF);
    tick();
    chk("unmapped bus_err", 32'(bus_err), 32'd1);
    chk("unmapped waitb", 32'(waitb), 32'd1);
    chk("unmapped db_i", 32'(db_i), 32'hFF);
    chk("unmapped busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("unmapped bus_err pulse end", 32'(bus_err), 32'd0);
    tick();
    chk("unmapped held strobe bus_err", 32'(bus_err), 32'd0);
    wrb = 1'b1;
    tick();
    wrb = 1'b0;
    tick();
    chk("unmapped second access bus_err", 32'(bus_err), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
